// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction memory responder with fixed fetch latency
// Single-outstanding fetch port with preload write side.
module imem_responder #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter int unsigned LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [31:0]           req_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_data,
   output logic [1:0]            rsp_err,
   input  logic                  ld_we,
   input  logic [DEPTH_LOG2-1:0] ld_idx,
   input  logic [31:0]           ld_data
);
   localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [32:0] SPAN     = 33'd4 << DEPTH_LOG2;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic [31:0]           mem [DEPTH];
   logic [31:0]           off;
   logic [DEPTH_LOG2-1:0] idx;
   logic [1:0]            acc_err;
   logic [31:0]           acc_data;
   logic [31:0]           cap_data;
   logic [1:0]            cap_err;

   // The explicit below-base compare keeps the check correct even if BASE+SPAN wraps.
   always_comb begin
      off = req_addr - BASE_ADDR;
      idx = off[DEPTH_LOG2+1:2];
      if (req_addr[1:0] != 2'b00)
         acc_err = 2'b01;
      else if ((req_addr < BASE_ADDR) || ({1'b0, off} >= SPAN))
         acc_err = 2'b10;
      else
         acc_err = 2'b00;
      acc_data = (acc_err == 2'b00) ? mem[idx] : 32'h0;
   end

   always_ff @(posedge clk) begin
      if (ld_we && !rst)
         mem[ld_idx] <= ld_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= 32'h0;
         rsp_err   <= 2'b00;
         cap_data  <= 32'h0;
         cap_err   <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  cap_data  <= acc_data;
                  cap_err   <= acc_err;
                  if (LATENCY == 1) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_data  <= acc_data;
                     rsp_err   <= acc_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               // Leaving as the counter reaches zero gives exactly LATENCY edges.
               cnt <= cnt - 4'd1;
               if (cnt <= 4'd1) begin
                  state     <= RESP;
                  cnt       <= 4'd0;
                  rsp_valid <= 1'b1;
                  rsp_data  <= cap_data;
                  rsp_err   <= cap_err;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - self-checking bench for imem_responder
// Two instances: LATENCY=2 (a) and LATENCY=1 (b), sharing clock, reset and preload port.
module tb_imem_responder;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, rsp_valid, rsp_ready;
   logic [31:0] req_addr, rsp_data;
   logic [1:0]  rsp_err;
   logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
   logic [31:0] b_req_addr, b_rsp_data;
   logic [1:0]  b_rsp_err;
   logic        ld_we;
   logic [9:0]  ld_idx;
   logic [31:0] ld_data;

   logic [31:0] model [1024];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   imem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data)
   );

   imem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
      .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: address rules evaluated with wide plain arithmetic.
   function automatic void model_rsp(input logic [31:0] a, output logic [1:0] e, output logic [31:0] d);
      longint unsigned la = 64'(a);
      longint unsigned lb = 64'(BASE);
      if (la % 4 != 0)
         e = 2'b01;
      else if (la < lb || la >= lb + 4 * 1024)
         e = 2'b10;
      else
         e = 2'b00;
      d = (e == 2'b00) ? model[int'((la - lb) / 4)] : 32'h0;
   endfunction

   function automatic logic [31:0] rand_addr();
      int unsigned s = $urandom_range(0, 9);
      logic [31:0] a = BASE + (32'($urandom_range(0, 1023)) << 2);
      case (s)
         0: a = a | 32'($urandom_range(1, 3));
         1: a = BASE - (32'($urandom_range(1, 64)) << 2);
         2: a = BASE + 32'h1000 + (32'($urandom_range(0, 255)) << 2);
         3: a = $urandom;
         default: ;
      endcase
      return a;
   endfunction

   task automatic fetch_a(input logic [31:0] addr, input int hold, input bit coll,
                          input logic [9:0] ci, input logic [31:0] cd);
      logic [1:0]  e_err;
      logic [31:0] e_data;
      logic [9:0]  wi;
      int          n;
      model_rsp(addr, e_err, e_data);
      wi = 10'((addr - BASE) >> 2);
      chk("a_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_addr  = addr;
      rsp_ready = (hold == 0);
      if (coll) begin
         ld_we = 1'b1; ld_idx = ci; ld_data = cd;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      ld_we     = 1'b0;
      if (coll) model[ci] = cd;
      n = 1;
      while (rsp_valid !== 1'b1 && n < 20) begin
         chk("a_wait_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
         n++;
      end
      chk("a_latency", n, 32'd2);
      chk("a_err", 32'(rsp_err), 32'(e_err));
      chk("a_data", rsp_data, e_data);
      for (int k = 0; k < hold; k++) begin
         req_valid = 1'b1; req_addr = $urandom;
         ld_we = 1'b1; ld_idx = wi; ld_data = $urandom;
         @(posedge clk); #1;
         model[wi] = ld_data;
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_data", rsp_data, e_data);
         chk("bp_err", 32'(rsp_err), 32'(e_err));
         chk("bp_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      ld_we     = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("a_rsp_done", 32'(rsp_valid), 32'd0);
      chk("a_ready_back", 32'(req_ready), 32'd1);
      chk("a_data_hold", rsp_data, e_data);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [1:0]  e;
      logic [31:0] d;
      rst = 1'b1;
      req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b1;
      b_req_valid = 1'b0; b_req_addr = 32'h0; b_rsp_ready = 1'b1;
      ld_we = 1'b0; ld_idx = 10'd0; ld_data = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_data", rsp_data, 32'h0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_ready_b", 32'(b_req_ready), 32'd1);

      for (int i = 0; i < 1024; i++) begin
         ld_we = 1'b1; ld_idx = 10'(i);
         ld_data = (i == 0) ? 32'h0010_0073 : (i == 5) ? 32'hAAAA_AAAA : $urandom;
         model[i] = ld_data;
         @(posedge clk); #1;
      end
      ld_we = 1'b0;

      fetch_a(BASE, 0, 1'b0, 10'd0, 32'h0);
      chk("first_word", rsp_data, 32'h0010_0073);
      fetch_a(BASE + 32'h4, 5, 1'b0, 10'd0, 32'h0);
      chk("after_bp_idle", 32'(rsp_valid), 32'd0);
      fetch_a(32'h8000_0002, 0, 1'b0, 10'd0, 32'h0);
      chk("mis_err", 32'(rsp_err), 32'd1);
      chk("mis_data", rsp_data, 32'h0);
      fetch_a(32'h8000_1000, 1, 1'b0, 10'd0, 32'h0);
      chk("hi_err", 32'(rsp_err), 32'd2);
      fetch_a(32'h7FFF_FFFC, 0, 1'b0, 10'd0, 32'h0);
      chk("lo_err", 32'(rsp_err), 32'd2);
      fetch_a(32'h8000_0FFC, 0, 1'b0, 10'd0, 32'h0);
      chk("last_err", 32'(rsp_err), 32'd0);

      fetch_a(32'h8000_0014, 0, 1'b1, 10'd5, 32'h5555_5555);
      chk("coll_old", rsp_data, 32'hAAAA_AAAA);
      fetch_a(32'h8000_0014, 0, 1'b0, 10'd0, 32'h0);
      chk("coll_new", rsp_data, 32'h5555_5555);

      // Reset during WAIT, with a preload attempt that must be ignored.
      req_valid = 1'b1; req_addr = BASE + 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_data", rsp_data, 32'h0);
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      ld_we = 1'b1; ld_idx = 10'd7; ld_data = ~model[7];
      @(posedge clk); #1;
      ld_we = 1'b0;
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
         @(posedge clk); #1;
      end
      fetch_a(BASE + 32'd28, 0, 1'b0, 10'd0, 32'h0);

      for (int i = 0; i < 40; i++) begin
         logic [9:0]  ci = ($urandom_range(0, 1) == 0) ? 10'd9 : 10'($urandom);
         logic [31:0] a  = ($urandom_range(0, 3) == 0) ? (BASE + 32'h24) : rand_addr();
         fetch_a(a, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), ci, $urandom);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            chk("idle_valid", 32'(rsp_valid), 32'd0);
         end
      end

      // LATENCY=1: request held high, one accept every two cycles.
      b_rsp_ready = 1'b1;
      b_req_valid = 1'b1;
      b_req_addr  = rand_addr();
      for (int i = 0; i < 8; i++) begin
         model_rsp(b_req_addr, e, d);
         chk("b_ready_idle", 32'(b_req_ready), 32'd1);
         @(posedge clk); #1;
         chk("b_valid_1cyc", 32'(b_rsp_valid), 32'd1);
         chk("b_data", b_rsp_data, d);
         chk("b_err", 32'(b_rsp_err), 32'(e));
         chk("b_ready_resp", 32'(b_req_ready), 32'd0);
         if (i == 7) b_req_valid = 1'b0;
         else b_req_addr = (i < 3) ? (BASE + 32'(i * 4)) : rand_addr();
         @(posedge clk); #1;
         chk("b_rsp_done", 32'(b_rsp_valid), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
